// File: rtl/matrix_pkg.sv
// Shared widths, coefficients and FSM encoding for the 2x2 inverse matrix transform.
package matrix_pkg;
  localparam int W_IN   = 17;
  localparam int W_OUT  = 13;
  localparam int W_COEF = 19;
  localparam int FRAC   = 14;
  localparam int W_PROD = W_COEF + W_IN;
  localparam int W_ACC  = W_PROD + 1;

  // Forward transform C in Q5.14, kept alongside K for the loopback path.
  localparam logic signed [W_COEF-1:0] C11 = -19'sd1802;
  localparam logic signed [W_COEF-1:0] C12 =  19'sd37683;
  localparam logic signed [W_COEF-1:0] C21 =  19'sd51446;
  localparam logic signed [W_COEF-1:0] C22 = -19'sd184320;

  localparam logic signed [W_COEF-1:0] K11 = 19'sd30800;
  localparam logic signed [W_COEF-1:0] K12 = 19'sd6297;
  localparam logic signed [W_COEF-1:0] K21 = 19'sd8596;
  localparam logic signed [W_COEF-1:0] K22 = 19'sd301;

  localparam logic signed [W_OUT-1:0] SAT_MAX = 13'sd4095;
  localparam logic signed [W_OUT-1:0] SAT_MIN = -13'sd4096;

  typedef enum logic [2:0] {
    S_IDLE, S_MA0, S_MA1, S_MB0, S_MB1, S_OUT
  } state_e;
endpackage

// File: rtl/mac_rs.sv
// Registered signed MAC with combinational round-half-up and 13-bit saturation of acc+product.
module mac_rs
  import matrix_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [W_COEF-1:0] coef,
  input  logic signed [W_IN-1:0]   opnd,
  output logic signed [W_OUT-1:0]  res,
  output logic                     sat
);
  logic signed [W_PROD-1:0] prod;
  logic signed [W_ACC-1:0]  acc_q, acc_d, sum, sh;

  always_comb begin
    prod  = W_PROD'(coef) * W_PROD'(opnd);
    sum   = (clr ? '0 : acc_q) + W_ACC'(prod);
    acc_d = en ? sum : acc_q;
    // Round half up before the arithmetic shift; sum can never reach the acc limits.
    sh    = (sum + W_ACC'(38'sd1 <<< (FRAC - 1))) >>> FRAC;
    res   = sh[W_OUT-1:0];
    sat   = 1'b0;
    if (sh > W_ACC'(SAT_MAX)) begin
      res = SAT_MAX;
      sat = 1'b1;
    end else if (sh < W_ACC'(SAT_MIN)) begin
      res = SAT_MIN;
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
endmodule

// File: rtl/matrix_inverse_seq.sv
// Inverse 2x2 transform (Y,Z) -> (A,B) using one time-shared multiplier, 4 MAC cycles per sample.
module matrix_inverse_seq
  import matrix_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W_IN-1:0]  Y,
  input  logic signed [W_IN-1:0]  Z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [W_OUT-1:0] A,
  output logic signed [W_OUT-1:0] B,
  output logic [1:0]              out_sat
);
  state_e                  state_q, state_d;
  logic signed [W_IN-1:0]  y_q, y_d, z_q, z_d;
  logic signed [W_OUT-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]              sat_q, sat_d;
  logic                    in_xfer, mac_en, mac_clr, mac_sat;
  logic signed [W_COEF-1:0] coef;
  logic signed [W_IN-1:0]  opnd;
  logic signed [W_OUT-1:0] mac_res;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    z_d     = z_q;
    a_d     = a_q;
    b_d     = b_q;
    sat_d   = sat_q;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    coef    = K11;
    opnd    = y_q;
    in_ready  = (state_q == S_IDLE) || (state_q == S_OUT && out_ready);
    in_xfer   = in_valid && in_ready;
    out_valid = (state_q == S_OUT);
    case (state_q)
      S_IDLE: ;
      S_MA0: begin
        mac_en = 1'b1; mac_clr = 1'b1; coef = K11; opnd = y_q;
        state_d = S_MA1;
      end
      S_MA1: begin
        coef = K12; opnd = z_q;
        a_d = mac_res; sat_d[1] = mac_sat;
        state_d = S_MB0;
      end
      S_MB0: begin
        mac_en = 1'b1; mac_clr = 1'b1; coef = K21; opnd = y_q;
        state_d = S_MB1;
      end
      S_MB1: begin
        coef = K22; opnd = z_q;
        b_d = mac_res; sat_d[0] = mac_sat;
        state_d = S_OUT;
      end
      S_OUT: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A new sample may be accepted in the same cycle the previous result leaves.
    if (in_xfer) begin
      y_d = Y;
      z_d = Z;
      state_d = S_MA0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      z_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      z_q     <= z_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sat_q   <= sat_d;
    end

  mac_rs u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (mac_en),
    .clr  (mac_clr),
    .coef (coef),
    .opnd (opnd),
    .res  (mac_res),
    .sat  (mac_sat)
  );

  assign A       = a_q;
  assign B       = b_q;
  assign out_sat = sat_q;
endmodule

// File: tb/tb_matrix_inverse_seq.sv
// Directed-vector bench for matrix_inverse_seq plus a randomized valid/ready scoreboard pass.
module tb_matrix_inverse_seq;
  logic               clk = 1'b0;
  logic               rst_n, in_valid, in_ready, out_valid, out_ready;
  logic signed [16:0] Y, Z;
  logic signed [12:0] A, B;
  logic [1:0]         out_sat;
  int n_chk = 0, n_fail = 0;

  localparam int NRND = 2000;

  always #5 clk = ~clk;

  matrix_inverse_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Y(Y), .Z(Z), .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .out_sat(out_sat)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference from the arithmetic definition: round half up, floor shift, clamp.
  function automatic void ref_rs(input longint s, output int r, output logic sat);
    longint q;
    q = (s + 8192) >>> 14;
    sat = 1'b0;
    if (q > 4095) begin q = 4095; sat = 1'b1; end
    else if (q < -4096) begin q = -4096; sat = 1'b1; end
    r = int'(q);
  endfunction

  function automatic void model(input int y, input int z, output int a, output int b, output logic [1:0] s);
    ref_rs(longint'(30800) * y + longint'(6297) * z, a, s[1]);
    ref_rs(longint'(8596) * y + longint'(301) * z, b, s[0]);
  endfunction

  task automatic send(input int y, input int z);
    @(negedge clk);
    chk("in_ready_before_send", 32'(in_ready), 1);
    in_valid = 1'b1; Y = 17'(y); Z = 17'(z);
    @(posedge clk);
    #1 in_valid = 1'b0; Y = 17'($urandom); Z = 17'($urandom);
  endtask

  // Call right after the accepting edge; returns at the negedge where out_valid is seen.
  task automatic wait_out(input string tag);
    int lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
  endtask

  task automatic expect_ab(input string tag, input int ea, input int eb, input int es);
    chk({tag, "_A"}, 32'(A), ea);
    chk({tag, "_B"}, 32'(B), eb);
    chk({tag, "_sat"}, 32'(out_sat), es);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic vec(input string tag, input int y, input int z, input int ea, input int eb, input int es);
    send(y, z);
    wait_out(tag);
    expect_ab(tag, ea, eb, es);
    pop();
  endtask

  initial begin
    int qa[$], qb[$], qs[$];
    int pushed, popped, cyc, ea, eb;
    logic [1:0] es;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; Y = '0; Z = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_A", 32'(A), 0);
    chk("rst_B", 32'(B), 0);
    chk("rst_sat", 32'(out_sat), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);

    vec("nominal", 104, -249, 100, 50, 0);
    vec("pos_one", 1, 0, 2, 1, 0);
    vec("neg_one", -1, 0, -2, -1, 0);
    vec("zero", 0, 0, 0, 0, 0);
    vec("sat_pos", 65535, 0, 4095, 4095, 3);
    vec("sat_neg", -65536, 0, -4096, -4096, 3);

    // Backpressure: hold the result, then overlap output and input transfers.
    send(104, -249);
    wait_out("bp");
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      expect_ab("bp_hold", 100, 50, 0);
    end
    out_ready = 1'b1; in_valid = 1'b1; Y = 17'sd1; Z = 17'sd0;
    #1 chk("bp_overlap_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b0; Y = 17'($urandom); Z = 17'($urandom);
    wait_out("bp_next");
    expect_ab("bp_next", 2, 1, 0);
    pop();

    // Reset while in MB0: no result may appear for that sample.
    send(104, -249);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midrst_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 1);
    begin
      int seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("midrst_no_output", seen, 0);
    end
    vec("after_rst", 104, -249, 100, 50, 0);

    // Random traffic against the queue model.
    pushed = 0; popped = 0; cyc = 0;
    while (popped < NRND && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (pushed < NRND) && ($urandom_range(0, 3) != 0);
      Y = 17'($urandom); Z = 17'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        model(int'(Y), int'(Z), ea, eb, es);
        qa.push_back(ea); qb.push_back(eb); qs.push_back(int'(es));
        pushed++;
      end
      if (out_valid && out_ready) begin
        chk("rnd_pending", 32'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
          expect_ab("rnd", qa.pop_front(), qb.pop_front(), qs.pop_front());
          popped++;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rnd_all_out", popped, NRND);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
